mips_multi_cycle_ctrl: RTL and testbench

//  Main control FSM for the multi-cycle MIPS core; the producing end of the ALU control interface.

---
 rtl/mips_multi_cycle_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_mips_multi_cycle_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multi_cycle_ctrl.sv
// mips_multi_cycle_ctrl: main control FSM of the multi-cycle MIPS core.
// Sequences fetch/decode/execute/mem/writeback and drives datapath controls.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   opcode, funct         instruction fields from the IR
//   zero_flag             ALU zero flag (beq)
//   alu_control           000 AND 001 OR 010 ADD 100 SUB 101 MUL 110 SLT
//   alu_src_a/alu_src_b   ALU operand selects
//   pc_src, pc_en         PC source select and PC load enable
//   iord, mem_write       memory address select, memory write
//   ir_write, reg_write   IR load, register file write
//   reg_dst, mem_to_reg   write-back register / data selects
//   illegal_op            unsupported opcode/funct seen in DECODE
//   state, instr_count    debug state, retired instruction counter
//
// Build option: define MIPS_CTRL_MUL_EN to accept R-type funct 011000 (MUL).

module mips_multi_cycle_ctrl #(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   input  logic                zero_flag,
   output logic [2:0]          alu_control,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          pc_src,
   output logic                pc_en,
   output logic                iord,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                illegal_op,
   output logic [3:0]          state,
   output logic [RETIRE_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_JUMP   = 4'd12
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [RETIRE_W-1:0] r_instr_count;

   logic w_pc_write;
   logic w_branch;
   logic w_retire;

   logic w_op_r;
   logic w_op_lw;
   logic w_op_sw;
   logic w_op_beq;
   logic w_op_addi;
   logic w_op_j;
   logic w_funct_ok;

   function automatic logic f_funct_legal(input logic [5:0] f);
      case (f)
         6'b100000,
         6'b100010,
         6'b100100,
         6'b100101,
         6'b101010: f_funct_legal = 1'b1;
`ifdef MIPS_CTRL_MUL_EN
         6'b011000: f_funct_legal = 1'b1;
`endif
         default:   f_funct_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] f_exec_alu(input logic [5:0] f);
      case (f)
         6'b100000: f_exec_alu = 3'b010;
         6'b100010: f_exec_alu = 3'b100;
         6'b100100: f_exec_alu = 3'b000;
         6'b100101: f_exec_alu = 3'b001;
         6'b101010: f_exec_alu = 3'b110;
`ifdef MIPS_CTRL_MUL_EN
         6'b011000: f_exec_alu = 3'b101;
`endif
         default:   f_exec_alu = 3'b010;
      endcase
   endfunction

   assign w_op_r     = (opcode == 6'b000000);
   assign w_op_lw    = (opcode == 6'b100011);
   assign w_op_sw    = (opcode == 6'b101011);
   assign w_op_beq   = (opcode == 6'b000100);
   assign w_op_addi  = (opcode == 6'b001000);
   assign w_op_j     = (opcode == 6'b000010);
   assign w_funct_ok = f_funct_legal(funct);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RESET;
      end else begin
         r_state <= w_next;
      end
   end

   // Every retiring state leads straight back to FETCH, so counting
   // while in one of them counts on the edge that leaves it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr_count <= '0;
      end else if (w_retire) begin
         r_instr_count <= r_instr_count + RETIRE_W'(1);
      end
   end

   always_comb begin
      w_next      = S_FETCH;
      alu_control = 3'b010;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      pc_src      = 2'b00;
      iord        = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      illegal_op  = 1'b0;
      w_pc_write  = 1'b0;
      w_branch    = 1'b0;
      w_retire    = 1'b0;
      case (r_state)
         S_RESET: begin
            w_next = S_FETCH;
         end
         S_FETCH: begin
            alu_src_b  = 2'b01;
            ir_write   = 1'b1;
            w_pc_write = 1'b1;
            w_next     = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            unique case (1'b1)
               w_op_r: begin
                  if (w_funct_ok) begin
                     w_next = S_EXEC;
                  end else begin
                     illegal_op = 1'b1;
                     w_next     = S_FETCH;
                  end
               end
               w_op_lw,
               w_op_sw:   w_next = S_MEMADR;
               w_op_beq:  w_next = S_BRANCH;
               w_op_addi: w_next = S_ADDIEX;
               w_op_j:    w_next = S_JUMP;
               default: begin
                  illegal_op = 1'b1;
                  w_next     = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            w_next    = w_op_sw ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            iord   = 1'b1;
            w_next = S_MEMWB;
         end
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            w_retire   = 1'b1;
            w_next     = S_FETCH;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            w_retire  = 1'b1;
            w_next    = S_FETCH;
         end
         S_EXEC: begin
            alu_src_a   = 1'b1;
            alu_control = f_exec_alu(funct);
            w_next      = S_ALUWB;
         end
         S_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            w_retire  = 1'b1;
            w_next    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a   = 1'b1;
            alu_control = 3'b100;
            pc_src      = 2'b01;
            w_branch    = 1'b1;
            w_retire    = 1'b1;
            w_next      = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            w_next    = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            w_retire  = 1'b1;
            w_next    = S_FETCH;
         end
         S_JUMP: begin
            pc_src     = 2'b10;
            w_pc_write = 1'b1;
            w_retire   = 1'b1;
            w_next     = S_FETCH;
         end
         default: begin
            // unused codes: everything idle, resume at FETCH
            alu_control = 3'b000;
            w_next      = S_FETCH;
         end
      endcase
   end

   assign pc_en       = w_pc_write | (w_branch & zero_flag);
   assign state       = r_state;
   assign instr_count = r_instr_count;

endmodule

// File: tb/tb_mips_multi_cycle_ctrl.sv
// tb_mips_multi_cycle_ctrl: scoreboard bench for the multi-cycle MIPS control FSM.
// Random instruction stream vs. a per-instruction cycle-sequence reference.

module tb_mips_multi_cycle_ctrl;

   typedef struct packed {
      logic [3:0]  st;
      logic [2:0]  alu;
      logic        sa;
      logic [1:0]  sb;
      logic [1:0]  ps;
      logic        pe;
      logic        iord;
      logic        mw;
      logic        irw;
      logic        rw;
      logic        rd;
      logic        m2r;
      logic        ill;
      logic [31:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       zero_flag = 1'b0;

   logic [2:0]  alu1, alu2;
   logic        sa1, sa2;
   logic [1:0]  sb1, sb2, ps1, ps2;
   logic        pe1, pe2, io1, io2, mw1, mw2, ir1, ir2;
   logic        rw1, rw2, rd1, rd2, mr1, mr2, il1, il2;
   logic [3:0]  st1, st2;
   logic [31:0] cnt1;
   logic [2:0]  cnt2;

   int   errors = 0;
   int   checks = 0;
   bit   mon_on = 1'b0;
   exp_t q[$];
   int   model_cnt = 0;

   always #5 clk = ~clk;

   mips_multi_cycle_ctrl #(.RETIRE_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
      .zero_flag(zero_flag), .alu_control(alu1), .alu_src_a(sa1),
      .alu_src_b(sb1), .pc_src(ps1), .pc_en(pe1), .iord(io1),
      .mem_write(mw1), .ir_write(ir1), .reg_write(rw1), .reg_dst(rd1),
      .mem_to_reg(mr1), .illegal_op(il1), .state(st1),
      .instr_count(cnt1)
   );

   // narrow counter instance so wrap-around is reachable
   mips_multi_cycle_ctrl #(.RETIRE_W(3)) dut_w (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
      .zero_flag(zero_flag), .alu_control(alu2), .alu_src_a(sa2),
      .alu_src_b(sb2), .pc_src(ps2), .pc_en(pe2), .iord(io2),
      .mem_write(mw2), .ir_write(ir2), .reg_write(rw2), .reg_dst(rd2),
      .mem_to_reg(mr2), .illegal_op(il2), .state(st2),
      .instr_count(cnt2)
   );

   function automatic exp_t got1();
      return '{st1, alu1, sa1, sb1, ps1, pe1, io1, mw1, ir1,
               rw1, rd1, mr1, il1, cnt1};
   endfunction

   function automatic exp_t got2();
      return '{st2, alu2, sa2, sb2, ps2, pe2, io2, mw2, ir2,
               rw2, rd2, mr2, il2, {29'd0, cnt2}};
   endfunction

   function automatic exp_t narrow(exp_t e);
      exp_t r;
      r = e;
      r.cnt = e.cnt & 32'd7;
      return r;
   endfunction

   task automatic chk(string nm, exp_t g, exp_t e);
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", nm, g, e);
      end
   endtask

   function automatic exp_t rec(int st, int alu, int sa, int sb,
                                int ps, int pe, int io, int mw,
                                int irw, int rw, int rd, int m2r,
                                int ill, int cnt);
      exp_t r;
      r.st   = 4'(st);
      r.alu  = 3'(alu);
      r.sa   = 1'(sa);
      r.sb   = 2'(sb);
      r.ps   = 2'(ps);
      r.pe   = 1'(pe);
      r.iord = 1'(io);
      r.mw   = 1'(mw);
      r.irw  = 1'(irw);
      r.rw   = 1'(rw);
      r.rd   = 1'(rd);
      r.m2r  = 1'(m2r);
      r.ill  = 1'(ill);
      r.cnt  = 32'(cnt);
      return r;
   endfunction

   function automatic bit funct_legal(logic [5:0] f);
      bit ok;
      ok = (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
`ifdef MIPS_CTRL_MUL_EN
      ok = ok || (f == 6'b011000);
`endif
      return ok;
   endfunction

   function automatic int funct_alu(logic [5:0] f);
      if (f == 6'b100010) return 4;
      if (f == 6'b100100) return 0;
      if (f == 6'b100101) return 1;
      if (f == 6'b101010) return 6;
      if (f == 6'b011000) return 5;
      return 2;
   endfunction

   // Reference: the full per-cycle output sequence of one instruction,
   // pushed to the scoreboard. Returns the cycle count.
   function automatic int push_instr(logic [5:0] op, logic [5:0] fn,
                                     logic z);
      int c;
      int ill;
      int n;
      c   = model_cnt;
      ill = 0;
      n   = 0;
      q.push_back(rec(1, 2, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, c));
      if (op == 6'b000000 && !funct_legal(fn)) ill = 1;
      if (!(op inside {6'b000000, 6'b100011, 6'b101011,
                       6'b000100, 6'b001000, 6'b000010})) ill = 1;
      q.push_back(rec(2, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, ill, c));
      n = 2;
      if (ill == 0) begin
         case (op)
            6'b100011: begin
               q.push_back(rec(3, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, c));
               q.push_back(rec(4, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, c));
               q.push_back(rec(5, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, c));
               n = 5;
            end
            6'b101011: begin
               q.push_back(rec(3, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, c));
               q.push_back(rec(6, 2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, c));
               n = 4;
            end
            6'b000000: begin
               q.push_back(rec(7, funct_alu(fn), 1, 0, 0, 0, 0, 0, 0,
                               0, 0, 0, 0, c));
               q.push_back(rec(8, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, c));
               n = 4;
            end
            6'b000100: begin
               q.push_back(rec(9, 4, 1, 0, 1, int'(z), 0, 0, 0,
                               0, 0, 0, 0, c));
               n = 3;
            end
            6'b001000: begin
               q.push_back(rec(10, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, c));
               q.push_back(rec(11, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, c));
               n = 4;
            end
            default: begin
               q.push_back(rec(12, 2, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, c));
               n = 3;
            end
         endcase
         model_cnt = model_cnt + 1;
      end
      return n;
   endfunction

   task automatic run_one(logic [5:0] op, logic [5:0] fn, logic z);
      int n;
      n = push_instr(op, fn, z);
      opcode    = op;
      funct     = fn;
      zero_flag = z;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_random(int num);
      logic [5:0] op, fn;
      logic       z;
      int         k;
      for (int i = 0; i < num; i++) begin
         k  = $urandom_range(0, 8);
         fn = 6'($urandom);
         z  = 1'($urandom);
         case (k)
            0: op = 6'b100011;
            1: op = 6'b101011;
            2: begin
               op = 6'b000000;
               fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) :
                    ($urandom_range(0, 1) == 0) ? 6'b100000 : 6'b100010;
            end
            3: op = 6'b000100;
            4: op = 6'b001000;
            5: op = 6'b000010;
            6: begin
               op = 6'b000000;
               fn = 6'b011000;
            end
            7: begin
               op = 6'b000000;
               case ($urandom_range(0, 2))
                  0: fn = 6'b100100;
                  1: fn = 6'b100101;
                  default: fn = 6'b101010;
               endcase
            end
            default: op = 6'($urandom);
         endcase
         run_one(op, fn, z);
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard empty: got state=%0d expected none",
                     st1);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("cycle", got1(), e);
            chk("cycle_w3", got2(), narrow(e));
         end
      end
   end

   initial begin
      exp_t rst_rec;
      rst_rec = rec(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("reset", got1(), rst_rec);
      end
      rst_n = 1'b1;
      #1;
      chk("reset_release", got1(), rst_rec);
      @(posedge clk);
      #1;
      mon_on = 1'b1;

      // directed cases first
      run_one(6'b100011, 6'h00, 1'b0);
      run_one(6'b000000, 6'b100010, 1'b0);
      run_one(6'b000100, 6'h00, 1'b1);
      run_one(6'b000100, 6'h00, 1'b0);
      run_one(6'b111111, 6'h00, 1'b0);
      run_one(6'b000000, 6'b011000, 1'b0);
      run_one(6'b000000, 6'b111111, 1'b1);
      run_random(60);

      // reset mid-store
      mon_on = 1'b0;
      chk("queue_drained", exp_t'(q.size()), exp_t'(0));
      opcode = 6'b101011;
      funct  = 6'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("memwr", got1(),
          rec(6, 2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, model_cnt));
      rst_n = 1'b0;
      #1;
      model_cnt = 0;
      chk("async_reset", got1(), rst_rec);
      chk("async_reset_w3", got2(), rst_rec);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_on = 1'b1;
      run_random(40);
      mon_on = 1'b0;
      chk("queue_end", exp_t'(q.size()), exp_t'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
